cmd_stream_tx: RTL and testbench
================================

# cmd_stream_tx

Command stream transmitter: buffers 32-bit command words written by the host and drives them out as an AXI-stream master into the rasterizer's command slave (`cmd_axis_*`). It sits between the host bus glue and the `graphite` command port. It absorbs host bursts, holds `tvalid`/`tdata` stable under backpressure, and can optionally fence the stream until the rasterizer signals a buffer swap.

## Interface
- `DEPTH`, 16: total words held (FIFO plus output stage); power of two, at least 2.
- `clk`  in  1: single clock, all logic rising-edge.
- `reset_i`  in  1: synchronous, active-high reset.
- `host_wr_i`  in  1: write strobe; one word per cycle.
- `host_data_i`  in  32: command word.
- `host_fence_i`  in  1: marks the written word as a fence; ignored when the feature is compiled out.
- `host_full_o`  out  1: asserted when level == DEPTH.
- `host_level_o`  out  $clog2(DEPTH)+1: words currently held.
- `overflow_o`  out  1: sticky; set by a write while full.
- `cmd_axis_tvalid_o`  out  1: AXI-stream valid.
- `cmd_axis_tready_i`  in  1: AXI-stream ready.
- `cmd_axis_tdata_o`  out  32: AXI-stream data.
- `swap_i`  in  1: single-cycle swap pulse from the rasterizer (`swap_o`).
- `busy_o`  out  1: level != 0 or state == WAIT_SWAP.

## Operation
- **Storage.** Circular FIFO with registered output stage. `host_level_o` counts every accepted word not yet handshaken downstream.
- **Write acceptance.**
  - A write is accepted when `host_wr_i` is high and `host_full_o` is low; full is sampled at the start of the cycle.
  - A write while full is dropped, sets `overflow_o`, and leaves level unchanged. This holds even if a downstream handshake happens in the same cycle.
- **Handshake.** A word transfers on a cycle with `cmd_axis_tvalid_o && cmd_axis_tready_i`.
  - Once `tvalid` is asserted, `tvalid` and `tdata` hold until that handshake.
  - `tvalid` never depends combinationally on `tready`.
- **Level update.** Each cycle, level += write_accepted − handshake. A simultaneous accepted write and handshake leaves level unchanged.
- **Output stage refill.** The output stage reloads from the FIFO head in the same cycle it is handshaken, or whenever it is empty. This sustains one word per cycle.
- **Ordering.** Words leave strictly in write order.
- **Pointer wrap.** Pointers wrap modulo DEPTH with no bubble at wrap.
- **State machine.** Two states, SEND and WAIT_SWAP; reset state is SEND.
  - SEND → WAIT_SWAP on the handshake of a word tagged fence (feature compiled in only).
  - WAIT_SWAP: `tvalid` is 0. Host writes are still accepted up to DEPTH.
  - WAIT_SWAP → SEND on `swap_i` == 1.
  - `swap_i` in SEND, including the cycle of the fence handshake, is ignored and not latched.
- **Reset.** Reset mid-operation discards all held words, clears `overflow_o`, and returns to SEND.

## Timing
- Values after reset: `cmd_axis_tvalid_o`=0, `cmd_axis_tdata_o`=0, `host_full_o`=0, `host_level_o`=0, `overflow_o`=0, `busy_o`=0.
- Latency: a word written in cycle N into an empty block shows `tvalid`=1 with that data in cycle N+1. It is visible at the output on the first edge after the write.
- `host_level_o` and `host_full_o` are registered and reflect the writes and handshakes of the previous cycle.
- Throughput: 1 word/cycle while `tready`=1 and the FIFO is non-empty.
- Fence path:
  - Fence handshake in cycle N: `tvalid`=0 from cycle N+1.
  - `swap_i` in cycle M: `tvalid` may reassert in cycle M+1 if words are held.
- `overflow_o` sets in the cycle after the rejected write.

## Configuration
- Macro: `CMD_TX_FENCE_EN`.
- **Defined:**
  - FIFO entries are 33 bits: data plus the fence tag.
  - The WAIT_SWAP state and `swap_i` handling are present.
- **Undefined:**
  - FIFO entries are 32 bits.
  - The state is permanently SEND.
  - `host_fence_i` and `swap_i` are ignored.
  - `busy_o` = level != 0.
- Ports are identical in both builds.

## Test plan
- **Burst under backpressure.** With DEPTH=16, write 0x1000_0000..0x1000_000F (16 words) with `tready`=0, then write 0xDEAD_BEEF.
  - `host_full_o`=1 after the 16th write; the 17th is dropped and `overflow_o`=1.
  - With `tready`=1, exactly 16 words emerge in order, and `tdata` held stable throughout the stall.
- **Streaming.** Continuous writes with `tready`=1.
  - One word per cycle, first `tvalid` one cycle after the first write.
  - Level stays at 1 and wraps past 40 words without loss.
- **Full boundary.** Simultaneous write and handshake while level==16: write rejected, level becomes 15, `overflow_o`=1.
- **Random ready.** 200 words under random `tready`: output order and data match the write order; no `tvalid` drop before a handshake.
- **Fence (`CMD_TX_FENCE_EN`).** Write A, B (fence), C, then:
  - `tvalid` goes to 0 after B's handshake; a `swap_i` pulse issued earlier had no effect.
  - C is sent one cycle after `swap_i`.
  - Without the macro, A, B, C are sent back-to-back.
- **Reset mid-burst.** Assert `reset_i` with 5 words held: all outputs return to reset values, and the next written word is the first sent.

Source files
------------

// File: rtl/cmd_stream_tx_if.sv
// AXI-stream command link between the command transmitter (master) and the rasterizer (slave).
interface cmd_stream_tx_if;
    logic        tvalid;
    logic        tready;
    logic [31:0] tdata;

    modport master (output tvalid, output tdata, input tready);
    modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/cmd_stream_tx.sv
// Host command FIFO plus registered AXI-stream output stage; a word written into an empty block is valid next cycle.
// Holds tvalid/tdata under backpressure; with CMD_TX_FENCE_EN a fence word stalls the stream until swap_i.
module cmd_stream_tx #(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_i,
    input  logic                   host_wr_i,
    input  logic [31:0]            host_data_i,
    input  logic                   host_fence_i,
    output logic                   host_full_o,
    output logic [$clog2(DEPTH):0] host_level_o,
    output logic                   overflow_o,
    cmd_stream_tx_if.master        cmd_axis,
    input  logic                   swap_i,
    output logic                   busy_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
`ifdef CMD_TX_FENCE_EN
    localparam int EW = 33;
`else
    localparam int EW = 32;
`endif

    typedef enum logic {ST_SEND, ST_WAIT_SWAP} state_e;

    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [EW-1:0] out_ent_q, out_ent_d;
    logic          out_vld_q, out_vld_d;
    logic          tvalid_q, tvalid_d;
    logic          full_q, full_d;
    logic          overflow_q, overflow_d;
    logic          busy_q, busy_d;
    state_e        state_q, state_d;

    logic [EW-1:0] wr_entry;
    logic [LW-1:0] fifo_cnt;
    logic          wr_acc;
    logic          hs;
    logic          load;
    logic          bypass;
    logic          mem_we;

`ifdef CMD_TX_FENCE_EN
    assign wr_entry = {host_fence_i, host_data_i};
`else
    logic unused_fence_swap;
    assign unused_fence_swap = host_fence_i ^ swap_i;
    assign wr_entry = host_data_i;
`endif

    assign cmd_axis.tvalid = tvalid_q;
    assign cmd_axis.tdata  = out_ent_q[31:0];
    assign host_full_o     = full_q;
    assign host_level_o    = level_q;
    assign overflow_o      = overflow_q;
    assign busy_o          = busy_q;

    always_comb begin
        wr_acc    = host_wr_i && !full_q;
        hs        = tvalid_q && cmd_axis.tready;
        // level covers the output stage too, so the FIFO proper holds level minus that word
        fifo_cnt  = level_q - LW'(out_vld_q);
        load      = !out_vld_q || hs;
        bypass    = load && (fifo_cnt == '0) && wr_acc;
        mem_we    = wr_acc && !bypass;

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        out_ent_d  = out_ent_q;
        out_vld_d  = out_vld_q;
        level_d    = level_q;
        state_d    = state_q;
        overflow_d = overflow_q || (host_wr_i && full_q);

        if (load) begin
            if (fifo_cnt != '0) begin
                out_vld_d = 1'b1;
                out_ent_d = mem_q[rd_ptr_q];
                rd_ptr_d  = rd_ptr_q + AW'(1);
            end else if (wr_acc) begin
                out_vld_d = 1'b1;
                out_ent_d = wr_entry;
            end else begin
                out_vld_d = 1'b0;
            end
        end

        if (mem_we) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end

        unique case ({wr_acc, hs})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

`ifdef CMD_TX_FENCE_EN
        // swap_i is only meaningful once parked; a pulse in SEND is dropped
        unique case (state_q)
            ST_SEND:      if (hs && out_ent_q[32]) state_d = ST_WAIT_SWAP;
            ST_WAIT_SWAP: if (swap_i) state_d = ST_SEND;
            default:      state_d = ST_SEND;
        endcase
`else
        state_d = ST_SEND;
`endif

        full_d   = (level_d == LW'(DEPTH));
        tvalid_d = out_vld_d && (state_d == ST_SEND);
        busy_d   = (level_d != '0) || (state_d == ST_WAIT_SWAP);
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            out_ent_q  <= '0;
            out_vld_q  <= 1'b0;
            tvalid_q   <= 1'b0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            state_q    <= ST_SEND;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            out_ent_q  <= out_ent_d;
            out_vld_q  <= out_vld_d;
            tvalid_q   <= tvalid_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
            busy_q     <= busy_d;
            state_q    <= state_d;
        end
    end

    // Storage needs no reset: pointers and level define which entries are live.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end
endmodule

// File: tb/tb_cmd_stream_tx.sv
// Bench for cmd_stream_tx: fixed burst table, hand sequences and random traffic against a queue model.
module tb_cmd_stream_tx;
    localparam int DEPTH = 16;
`ifdef CMD_TX_FENCE_EN
    localparam bit FEN = 1'b1;
`else
    localparam bit FEN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        host_wr_i = 1'b0;
    logic [31:0] host_data_i = '0;
    logic        host_fence_i = 1'b0;
    logic        host_full_o;
    logic [4:0]  host_level_o;
    logic        overflow_o;
    logic        swap_i = 1'b0;
    logic        busy_o;

    cmd_stream_tx_if axis ();

    cmd_stream_tx #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset_i      (reset_i),
        .host_wr_i    (host_wr_i),
        .host_data_i  (host_data_i),
        .host_fence_i (host_fence_i),
        .host_full_o  (host_full_o),
        .host_level_o (host_level_o),
        .overflow_o   (overflow_o),
        .cmd_axis     (axis),
        .swap_i       (swap_i),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int n_hs  = 0;

    // Reference model: words held in write order, tagged with fence bit 32
    logic [32:0] mq[$];
    bit          m_ovf  = 1'b0;
    bit          m_wait = 1'b0;

    logic        prev_vld = 1'b0;
    logic        prev_rdy = 1'b0;
    logic [31:0] prev_dat = '0;

    typedef struct {
        logic        wr;
        logic [31:0] d;
        logic        rdy;
        logic [4:0]  lvl;
        logic        vld;
        logic [31:0] dat;
        logic        full;
        logic        ovf;
    } vec_t;
    vec_t tbl[34];

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_check();
        bit exp_vld;
        exp_vld = (mq.size() > 0) && !m_wait;
        cmp("m_level", 32'(host_level_o), 32'(mq.size()));
        cmp("m_full", 32'(host_full_o), 32'(mq.size() == DEPTH));
        cmp("m_ovf", 32'(overflow_o), 32'(m_ovf));
        cmp("m_tvalid", 32'(axis.tvalid), 32'(exp_vld));
        cmp("m_busy", 32'(busy_o), 32'((mq.size() > 0) || m_wait));
        if (exp_vld) cmp("m_tdata", axis.tdata, mq[0][31:0]);
    endtask

    task automatic model_step(input logic wr, input logic [31:0] d, input logic f,
                              input logic rdy, input logic sw);
        bit full, hs, fe;
        full = (mq.size() == DEPTH);
        hs   = (mq.size() > 0) && !m_wait && rdy;
        fe   = 1'b0;
        if (hs) begin
            fe = mq[0][32];
            void'(mq.pop_front());
            n_hs++;
        end
        if (wr && !full) mq.push_back({f & FEN, d});
        if (wr && full) m_ovf = 1'b1;
        if (m_wait) begin
            if (sw) m_wait = 1'b0;
        end else if (hs && fe && FEN) begin
            m_wait = 1'b1;
        end
    endtask

    task automatic cyc(input logic wr, input logic [31:0] d, input logic f,
                       input logic rdy, input logic sw);
        host_wr_i    = wr;
        host_data_i  = d;
        host_fence_i = f;
        axis.tready  = rdy;
        swap_i       = sw;
        if (prev_vld && !prev_rdy) begin
            cmp("hold_tvalid", 32'(axis.tvalid), 32'd1);
            cmp("hold_tdata", axis.tdata, prev_dat);
        end
        model_check();
        prev_vld = axis.tvalid;
        prev_rdy = rdy;
        prev_dat = axis.tdata;
        model_step(wr, d, f, rdy, sw);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_i      = 1'b1;
        host_wr_i    = 1'b0;
        host_fence_i = 1'b0;
        axis.tready  = 1'b0;
        swap_i       = 1'b0;
        @(posedge clk);
        #1;
        reset_i  = 1'b0;
        mq.delete();
        m_ovf    = 1'b0;
        m_wait   = 1'b0;
        prev_vld = 1'b0;
        cmp("rst_tvalid", 32'(axis.tvalid), 32'd0);
        cmp("rst_tdata", axis.tdata, 32'd0);
        cmp("rst_level", 32'(host_level_o), 32'd0);
        cmp("rst_full", 32'(host_full_o), 32'd0);
        cmp("rst_ovf", 32'(overflow_o), 32'd0);
        cmp("rst_busy", 32'(busy_o), 32'd0);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200 && mq.size() > 0; i++) cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
        cmp(name, 32'(host_level_o), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        int written;
        logic wr;
        axis.tready = 1'b0;

        for (int i = 0; i < 16; i++)
            tbl[i] = '{1'b1, 32'h1000_0000 + 32'(i), 1'b0, 5'(i), (i > 0), 32'h1000_0000, 1'b0, 1'b0};
        tbl[16] = '{1'b1, 32'hDEAD_BEEF, 1'b0, 5'd16, 1'b1, 32'h1000_0000, 1'b1, 1'b0};
        tbl[17] = '{1'b1, 32'h5555_5555, 1'b1, 5'd16, 1'b1, 32'h1000_0000, 1'b1, 1'b1};
        for (int k = 0; k < 15; k++)
            tbl[18 + k] = '{1'b0, 32'h0, 1'b1, 5'(15 - k), 1'b1, 32'h1000_0001 + 32'(k), 1'b0, 1'b1};
        tbl[33] = '{1'b0, 32'h0, 1'b1, 5'd0, 1'b0, 32'h0, 1'b0, 1'b1};

        do_reset();

        // Burst under backpressure, overflow, then full-boundary write+handshake
        for (int i = 0; i < 34; i++) begin
            cmp("tbl_level", 32'(host_level_o), 32'(tbl[i].lvl));
            cmp("tbl_tvalid", 32'(axis.tvalid), 32'(tbl[i].vld));
            cmp("tbl_full", 32'(host_full_o), 32'(tbl[i].full));
            cmp("tbl_ovf", 32'(overflow_o), 32'(tbl[i].ovf));
            if (tbl[i].vld) cmp("tbl_tdata", axis.tdata, tbl[i].dat);
            cyc(tbl[i].wr, tbl[i].d, 1'b0, tbl[i].rdy, 1'b0);
        end

        // Reset with 5 words held and overflow still set
        for (int i = 0; i < 5; i++) cyc(1'b1, 32'hA000_0000 + 32'(i), 1'b0, 1'b0, 1'b0);
        cmp("mid_level", 32'(host_level_o), 32'd5);
        do_reset();
        cyc(1'b1, 32'h0BAD_F00D, 1'b0, 1'b0, 1'b0);
        cmp("post_rst_tvalid", 32'(axis.tvalid), 32'd1);
        cmp("post_rst_tdata", axis.tdata, 32'h0BAD_F00D);
        drain("post_rst_drain");

        // Streaming: level pinned at 1, one word per cycle
        base = n_hs;
        for (int i = 0; i < 45; i++) begin
            cyc(1'b1, 32'hC000_0000 + 32'(i), 1'b0, 1'b1, 1'b0);
            if (i > 0) cmp("stream_level", 32'(host_level_o), 32'd1);
        end
        drain("stream_drain");
        cmp("stream_count", 32'(n_hs - base), 32'd45);

        // Random ready and stray swap pulses, 200 words
        base = n_hs;
        written = 0;
        for (int c = 0; c < 5000 && written < 200; c++) begin
            wr = (mq.size() < DEPTH) && ($urandom_range(3) != 0);
            if (wr) written++;
            cyc(wr, $urandom, 1'b0, 1'($urandom_range(1)), ($urandom_range(7) == 0));
        end
        drain("rand_drain");
        cmp("rand_count", 32'(n_hs - base), 32'd200);

        // Fence: A, B(fence), C; early swap pulses must not release the fence
        do_reset();
        cyc(1'b1, 32'hAAAA_0001, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'hBBBB_0002, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 32'hCCCC_0003, 1'b0, 1'b0, 1'b0);
        cmp("fence_a", axis.tdata, 32'hAAAA_0001);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
        cmp("fence_b_vld", 32'(axis.tvalid), 32'd1);
        cmp("fence_b", axis.tdata, 32'hBBBB_0002);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b1);
        if (FEN) begin
            for (int i = 0; i < 3; i++) begin
                cmp("fence_stall_vld", 32'(axis.tvalid), 32'd0);
                cmp("fence_stall_busy", 32'(busy_o), 32'd1);
                cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
            end
            cyc(1'b0, '0, 1'b0, 1'b1, 1'b1);
        end
        cmp("fence_c_vld", 32'(axis.tvalid), 32'd1);
        cmp("fence_c", axis.tdata, 32'hCCCC_0003);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
        cmp("fence_end_level", 32'(host_level_o), 32'd0);
        cmp("fence_end_busy", 32'(busy_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
